// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 2-flop synchronised rx in, dataRX/WR_RX out.
// Byte appears ~9.5 bit times + 3 clk after the start edge. There is no backpressure, so the consumer must take each byte within one frame.
module uart_byte_rx #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int BAUD    = 115200,
  parameter int WR_HOLD = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] dataRX,
  output logic       WR_RX,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int HW           = $clog2(WR_HOLD + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(WR_HOLD);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [HW-1:0] wr_cnt;
  logic          accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      dataRX    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            // A start bit that is already high again at its midpoint is a glitch
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            shift[idx] <= rx_s;
            cnt        <= '0;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              dataRX <= shift;
              state  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign accept = (state == STOP) && (cnt == BIT_LAST) && rx_s;

  // Stretched strobe so a slower px_clk domain sees at least two edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
    end else if (accept) begin
      wr_cnt <= HOLD_LOAD;
    end else if (wr_cnt != '0) begin
      wr_cnt <= wr_cnt - 1'b1;
    end
  end

  assign WR_RX = (wr_cnt != '0);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_byte_rx at 25 MHz / 115200 baud (217 clk per bit).
module tb_uart_byte_rx;

  localparam int BIT = 217;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] dataRX;
  logic       WR_RX;
  logic       frame_err;
  logic       busy;

  int errors;
  int checks;

  logic [7:0] rxq[$];
  int         ferr_cnt;
  int         hi_len;
  int         last_len;
  int         bad_len;
  int         bad_chg;
  logic       wr_prev;
  logic [7:0] data_prev;

  uart_byte_rx #(
    .CLK_HZ (25_000_000),
    .BAUD   (115200),
    .WR_HOLD(4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .dataRX   (dataRX),
    .WR_RX    (WR_RX),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    if (rxq.size() == 0) begin
      chk(tag, 32'hFFFF_FFFF, {24'd0, exp});
    end else begin
      v = rxq.pop_front();
      chk(tag, {24'd0, v}, {24'd0, exp});
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_v);
    rx = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bclk);
    end
    rx = stop_v;
    wait_clks(bclk);
    rx = 1'b1;
  endtask

  task automatic clear_mon();
    rxq.delete();
    ferr_cnt = 0;
    bad_len  = 0;
    bad_chg  = 0;
    last_len = 0;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (WR_RX && !wr_prev) rxq.push_back(dataRX);
      if (WR_RX) begin
        hi_len++;
      end else if (wr_prev) begin
        last_len = hi_len;
        if (hi_len != 4) bad_len++;
        hi_len = 0;
      end
      if (frame_err) ferr_cnt++;
      if (dataRX != data_prev && !(WR_RX && !wr_prev)) bad_chg++;
    end else begin
      hi_len = 0;
    end
    wr_prev   = WR_RX;
    data_prev = dataRX;
  end

  initial begin
    errors    = 0;
    checks    = 0;
    hi_len    = 0;
    wr_prev   = 1'b0;
    data_prev = 8'h00;
    clear_mon();
    rx   = 1'b1;
    rstn = 1'b0;

    // Reset values
    wait_clks(5);
    chk("rst_data", {24'd0, dataRX}, 32'h00);
    chk("rst_wr", {31'd0, WR_RX}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b1;
    wait_clks(5);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: single byte
    clear_mon();
    send_byte(8'h41, BIT, 1'b1);
    wait_clks(2 * BIT);
    chk("t1_cnt", rxq.size(), 32'd1);
    pop_chk("t1_val", 8'h41);
    chk("t1_len", last_len, 32'd4);
    chk("t1_ferr", ferr_cnt, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_data", {24'd0, dataRX}, 32'h41);

    // 2: back-to-back frames
    clear_mon();
    send_byte(8'h42, BIT, 1'b1);
    send_byte(8'h43, BIT, 1'b1);
    send_byte(8'h44, BIT, 1'b1);
    wait_clks(2 * BIT);
    chk("t2_cnt", rxq.size(), 32'd3);
    pop_chk("t2_b0", 8'h42);
    pop_chk("t2_b1", 8'h43);
    pop_chk("t2_b2", 8'h44);
    chk("t2_len", bad_len, 32'd0);
    chk("t2_ferr", ferr_cnt, 32'd0);

    // 3: 50-clk glitch
    clear_mon();
    rx = 1'b0;
    wait_clks(50);
    rx = 1'b1;
    wait_clks(10);
    chk("t3_busy_mid", {31'd0, busy}, 32'd1);
    wait_clks(60);
    chk("t3_busy_end", {31'd0, busy}, 32'd0);
    wait_clks(2 * BIT);
    chk("t3_cnt", rxq.size(), 32'd0);
    chk("t3_ferr", ferr_cnt, 32'd0);

    // 4: framing error then good byte
    clear_mon();
    send_byte(8'h44, BIT, 1'b0);
    wait_clks(2 * BIT);
    chk("t4_ferr", ferr_cnt, 32'd1);
    chk("t4_nostrobe", rxq.size(), 32'd0);
    chk("t4_hold", {24'd0, dataRX}, 32'h44);
    send_byte(8'h41, BIT, 1'b1);
    wait_clks(2 * BIT);
    chk("t4_cnt", rxq.size(), 32'd1);
    pop_chk("t4_val", 8'h41);
    chk("t4_ferr_end", ferr_cnt, 32'd1);
    chk("t4_chg", bad_chg, 32'd0);

    // 5: reset in data bit 3 of 0x41, line low across release
    clear_mon();
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(BIT);
    rx = 1'b0;
    wait_clks(2 * BIT);
    wait_clks(100);
    rstn = 1'b0;
    wait_clks(5);
    chk("t5_rst_data", {24'd0, dataRX}, 32'h00);
    chk("t5_rst_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b1;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(2 * BIT);
    chk("t5_nostrobe", rxq.size(), 32'd0);
    chk("t5_noferr", ferr_cnt, 32'd0);
    chk("t5_data0", {24'd0, dataRX}, 32'h00);
    send_byte(8'h43, BIT, 1'b1);
    wait_clks(2 * BIT);
    chk("t5_cnt", rxq.size(), 32'd1);
    pop_chk("t5_val", 8'h43);
    chk("t5_data", {24'd0, dataRX}, 32'h43);
    chk("t5_chg", bad_chg, 32'd0);

    // 6: +/-2% baud error
    clear_mon();
    send_byte(8'h55, 213, 1'b1);
    send_byte(8'hAA, 213, 1'b1);
    wait_clks(2 * BIT);
    send_byte(8'h55, 221, 1'b1);
    send_byte(8'hAA, 221, 1'b1);
    wait_clks(2 * BIT);
    chk("t6_cnt", rxq.size(), 32'd4);
    pop_chk("t6_fast55", 8'h55);
    pop_chk("t6_fastAA", 8'hAA);
    pop_chk("t6_slow55", 8'h55);
    pop_chk("t6_slowAA", 8'hAA);
    chk("t6_ferr", ferr_cnt, 32'd0);
    chk("t6_len", bad_len, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
